// File: rtl/c_skip_pipe_adder_pkg.sv
// Shared constants and the pipeline stage record for the carry-skip pipelined adder.
// The optional sub flag in the record exists only when C_SKIP_SUB_EN is defined.
package c_skip_pipe_adder_pkg;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_BLK   = 8;
   // Records are sized for the widest supported build; narrower builds zero-pad.
   localparam int REC_W     = DEF_WIDTH;

   typedef struct packed {
      logic             vld;
      logic [REC_W-1:0] ps;
      logic             carry;
      logic [REC_W-1:0] a;
      logic [REC_W-1:0] b;
`ifdef C_SKIP_SUB_EN
      logic             sub;
`endif
   } stage_rec_t;

endpackage

// File: rtl/c_skip_blk.sv
// Combinational carry-skip block: ripple add of BLK bits with a bypass of the
// carry-in when every bit propagates.
module c_skip_blk
   import c_skip_pipe_adder_pkg::*;
#(
   parameter int BLK = DEF_BLK
) (
   input  logic [BLK-1:0] a,
   input  logic [BLK-1:0] b,
   input  logic           cin,
   output logic [BLK-1:0] s,
   output logic           cout
);

   logic [BLK-1:0] p;
   logic [BLK:0]   c;

   always_comb begin
      p    = a ^ b;
      c    = '0;
      c[0] = cin;
      for (int j = 0; j < BLK; j++) begin
         c[j+1] = (a[j] & b[j]) | (p[j] & c[j]);
      end
      s    = p ^ c[BLK-1:0];
      cout = (&p) ? cin : c[BLK];
   end

endmodule

// File: rtl/c_skip_pipe_adder.sv
// Pipelined carry-skip adder: one BLK-bit block per stage, operands skewed by
// shifting, valid/ready handshake with full-pipeline stall. Optional subtract via C_SKIP_SUB_EN.
module c_skip_pipe_adder
   import c_skip_pipe_adder_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int BLK   = DEF_BLK
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [WIDTH:1] a,
   input  logic [WIDTH:1] b,
   input  logic           cin,
`ifdef C_SKIP_SUB_EN
   input  logic           sub,
`endif
   output logic           out_valid,
   input  logic           out_ready,
   output logic [WIDTH:1] s,
   output logic           cout,
   output logic           ovf
);

   localparam int NBLK = WIDTH / BLK;

   if (BLK < 1 || WIDTH < BLK || (WIDTH % BLK) != 0) begin : g_bad_cfg
      $error("c_skip_pipe_adder: WIDTH must be a positive multiple of BLK");
   end
   if (WIDTH > REC_W) begin : g_too_wide
      $error("c_skip_pipe_adder: WIDTH exceeds the stage record width");
   end

   stage_rec_t src   [NBLK];
   stage_rec_t nxt   [NBLK];
   stage_rec_t stg_p [NBLK];

   logic [NBLK-1:0][BLK-1:0] blk_a, blk_b, blk_s;
   logic [NBLK-1:0]          blk_ci, blk_co;
   logic                     stall, ovf_nxt, ovf_p;

   assign stall    = stg_p[NBLK-1].vld & ~out_ready;
   assign in_ready = ~rst & ~stall;

   // Stage inputs: stage 1 reads the ports, stage k reads register k-1.
   // The current block's operand bits always sit in the low BLK bits.
   always_comb begin
      src[0]                = '0;
      src[0].vld            = in_valid & in_ready;
      src[0].a[WIDTH-1:0]   = a;
      src[0].b[WIDTH-1:0]   = b;
`ifdef C_SKIP_SUB_EN
      src[0].sub            = sub;
      src[0].carry          = sub | cin;
`else
      src[0].carry          = cin;
`endif
      for (int i = 1; i < NBLK; i++) begin
         src[i] = stg_p[i-1];
      end
      for (int i = 0; i < NBLK; i++) begin
         blk_a[i]  = src[i].a[BLK-1:0];
`ifdef C_SKIP_SUB_EN
         blk_b[i]  = src[i].b[BLK-1:0] ^ {BLK{src[i].sub}};
`else
         blk_b[i]  = src[i].b[BLK-1:0];
`endif
         blk_ci[i] = src[i].carry;
      end
   end

   for (genvar i = 0; i < NBLK; i++) begin : g_blk
      c_skip_blk #(.BLK(BLK)) u_blk (
         .a    (blk_a[i]),
         .b    (blk_b[i]),
         .cin  (blk_ci[i]),
         .s    (blk_s[i]),
         .cout (blk_co[i])
      );
   end

   // Overflow from the top block: carry into the MSB is a^b^s at that bit.
   always_comb begin
      for (int i = 0; i < NBLK; i++) begin
         nxt[i]       = src[i];
         nxt[i].ps    = src[i].ps | (REC_W'(blk_s[i]) << (i * BLK));
         nxt[i].carry = blk_co[i];
         nxt[i].a     = src[i].a >> BLK;
         nxt[i].b     = src[i].b >> BLK;
      end
      ovf_nxt = blk_a[NBLK-1][BLK-1] ^ blk_b[NBLK-1][BLK-1] ^
                blk_s[NBLK-1][BLK-1] ^ blk_co[NBLK-1];
   end

   // Stage registers p1..pNBLK; the whole pipe holds on an output stall.
   always_ff @(posedge clk) begin
      if (!stall) begin
         stg_p <= nxt;
         ovf_p <= ovf_nxt;
      end
      if (rst) begin
         for (int i = 0; i < NBLK; i++) begin
            stg_p[i].vld <= 1'b0;
         end
         stg_p[NBLK-1].ps    <= '0;
         stg_p[NBLK-1].carry <= 1'b0;
         ovf_p               <= 1'b0;
      end
   end

   assign out_valid = stg_p[NBLK-1].vld;
   assign s         = stg_p[NBLK-1].ps[WIDTH-1:0];
   assign cout      = stg_p[NBLK-1].carry;
   assign ovf       = ovf_p;

endmodule
